// File: rtl/memctrl_sequencer.sv
// memctrl_sequencer: byte/halfword/word load-store sequencer onto a 4096x16 single-port synchronous memory.
// Define MEMCTRL_BYTE_RMW_EN to support byte stores via read-modify-write; otherwise byte stores are rejected.
module memctrl_sequencer #(
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH:0]   req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [31:0]           resp_rdata,
  input  logic [15:0]           MEM_MEMCTRL_from_mem_data,
  output logic                  MEMCTRL_MEM_to_mem_read_enable,
  output logic                  MEMCTRL_MEM_to_mem_write_enable,
  output logic                  MEMCTRL_MEM_to_mem_mem_enable,
  output logic [ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
  output logic [15:0]           MEMCTRL_MEM_to_mem_data
);
  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RDW, WR0, WR1,
`ifdef MEMCTRL_BYTE_RMW_EN
    RMW_RD, RMW_WAIT, RMW_WR,
`endif
    ERR
  } state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] h_q, h_d, addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic bsel_q, bsel_d;
  logic [15:0] hi_q, hi_d, lo_q, lo_d, data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic rd_q, rd_d, wr_q, wr_d, en_q, valid_q, valid_d, err_q, err_d;
  logic bad_req;
  logic [15:0] mem_in;
  assign mem_in = MEM_MEMCTRL_from_mem_data;
  assign bad_req = req_size == 2'b11 || (req_size != 2'b00 && req_addr[0]);
  assign req_ready = state_q == IDLE && !reset;
  assign resp_valid = valid_q;
  assign resp_error = err_q;
  assign resp_rdata = rdata_q;
  assign MEMCTRL_MEM_to_mem_read_enable = rd_q;
  assign MEMCTRL_MEM_to_mem_write_enable = wr_q;
  assign MEMCTRL_MEM_to_mem_mem_enable = en_q;
  assign MEMCTRL_MEM_to_mem_address = addr_q;
  assign MEMCTRL_MEM_to_mem_data = data_q;
  always_comb begin
    state_d = state_q;
    h_d = h_q;
    size_d = size_q;
    bsel_d = bsel_q;
    hi_d = hi_q;
    lo_d = lo_q;
    rdata_d = '0;
    addr_d = '0;
    data_d = '0;
    rd_d = 1'b0;
    wr_d = 1'b0;
    valid_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        h_d = req_addr[ADDR_WIDTH:1];
        size_d = req_size;
        bsel_d = req_addr[0];
        // Only the upper half of a word (or the store byte) is needed after the accept edge
        hi_d = req_size == 2'b00 ? {8'h00, req_wdata[7:0]} : req_wdata[31:16];
        if (bad_req) state_d = ERR;
        else if (!req_write) begin
          state_d = RD0;
          rd_d = 1'b1;
          addr_d = h_d;
        end else if (req_size != 2'b00) begin
          state_d = WR0;
          wr_d = 1'b1;
          addr_d = h_d;
          data_d = req_wdata[15:0];
        end else begin
`ifdef MEMCTRL_BYTE_RMW_EN
          state_d = RMW_RD;
          rd_d = 1'b1;
          addr_d = h_d;
`else
          state_d = ERR;
`endif
        end
      end
      RD0: begin
        state_d = size_q == 2'b10 ? RD1 : RDW;
        rd_d = size_q == 2'b10;
        addr_d = size_q == 2'b10 ? h_q + 1'b1 : '0;
      end
      RD1: begin
        state_d = RDW;
        lo_d = mem_in;
      end
      RDW: begin
        state_d = IDLE;
        valid_d = 1'b1;
        rdata_d = size_q == 2'b10 ? {mem_in, lo_q} :
                  size_q == 2'b01 ? {16'h0000, mem_in} :
                  {24'h000000, bsel_q ? mem_in[15:8] : mem_in[7:0]};
      end
      WR0: begin
        state_d = size_q == 2'b10 ? WR1 : IDLE;
        wr_d = size_q == 2'b10;
        addr_d = size_q == 2'b10 ? h_q + 1'b1 : '0;
        data_d = size_q == 2'b10 ? hi_q : '0;
        valid_d = size_q != 2'b10;
      end
      WR1: begin
        state_d = IDLE;
        valid_d = 1'b1;
      end
`ifdef MEMCTRL_BYTE_RMW_EN
      RMW_RD: state_d = RMW_WAIT;
      RMW_WAIT: begin
        state_d = RMW_WR;
        wr_d = 1'b1;
        addr_d = h_q;
        data_d = bsel_q ? {hi_q[7:0], mem_in[7:0]} : {mem_in[15:8], hi_q[7:0]};
      end
      RMW_WR: begin
        state_d = IDLE;
        valid_d = 1'b1;
      end
`endif
      ERR: begin
        state_d = IDLE;
        valid_d = 1'b1;
        err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      h_q <= '0;
      size_q <= '0;
      bsel_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      rdata_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      en_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      size_q <= size_d;
      bsel_q <= bsel_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      rdata_q <= rdata_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      en_q <= rd_d | wr_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_memctrl_sequencer.sv
// tb_memctrl_sequencer: directed and random load/store traffic against a TB-side memory and a reference model.
module tb_memctrl_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [1:0] req_size = '0;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [15:0] mem_dout = '0;
  logic mem_re, mem_we, mem_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];
  int checks = 0;
  int errors = 0;

  memctrl_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .MEM_MEMCTRL_from_mem_data(mem_dout),
    .MEMCTRL_MEM_to_mem_read_enable(mem_re),
    .MEMCTRL_MEM_to_mem_write_enable(mem_we),
    .MEMCTRL_MEM_to_mem_mem_enable(mem_en),
    .MEMCTRL_MEM_to_mem_address(mem_addr),
    .MEMCTRL_MEM_to_mem_data(mem_din)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en && mem_we) mem[mem_addr] = mem_din;
    if (mem_en && mem_re) mem_dout <= mem[mem_addr];
  end

  // Reference model: applies a request to ref_mem and predicts latency, result and access count.
  task automatic ref_txn(input logic w, input logic [1:0] sz, input logic [12:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd, output int nacc);
    logic [11:0] h, h1;
    h = a[12:1];
    h1 = h + 12'd1;
    err = sz == 2'd3 || (sz != 2'd0 && a[0]);
`ifndef MEMCTRL_BYTE_RMW_EN
    if (w && sz == 2'd0) err = 1'b1;
`endif
    rd = 0;
    lat = 1;
    nacc = 0;
    if (!err) begin
      if (!w) begin
        if (sz == 2'd2) begin rd = {ref_mem[h1], ref_mem[h]}; lat = 3; nacc = 2; end
        else if (sz == 2'd1) begin rd = {16'h0, ref_mem[h]}; lat = 2; nacc = 1; end
        else begin rd = {24'h0, a[0] ? ref_mem[h][15:8] : ref_mem[h][7:0]}; lat = 2; nacc = 1; end
      end else begin
        if (sz == 2'd2) begin ref_mem[h] = wd[15:0]; ref_mem[h1] = wd[31:16]; lat = 2; nacc = 2; end
        else if (sz == 2'd1) begin ref_mem[h] = wd[15:0]; lat = 1; nacc = 1; end
        else begin
          if (a[0]) ref_mem[h][15:8] = wd[7:0];
          else ref_mem[h][7:0] = wd[7:0];
          lat = 3;
          nacc = 2;
        end
      end
    end
  endtask

  // Drives one request, scrambles the request pins after acceptance, and records what the DUT did.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [12:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd, output int nacc,
                         output int first_en, output logic bad_en, output logic ready_ok, output logic stuck);
    lat = -1; err = 0; rd = 0; nacc = 0; first_en = 0; bad_en = 0; stuck = 0;
    @(negedge clock);
    ready_ok = req_ready;
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = 13'($urandom); req_wdata = $urandom;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      if (mem_en !== (mem_re | mem_we) || (mem_re && mem_we) || (!mem_en && (mem_addr != 0 || mem_din != 0)))
        bad_en = 1'b1;
      if (mem_en) begin
        nacc++;
        if (first_en == 0) first_en = c + 1;
      end
      if (resp_valid) begin
        lat = c; err = resp_error; rd = resp_rdata;
        break;
      end
    end
    if (lat >= 0) begin
      @(negedge clock);
      stuck = resp_valid;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom); req_addr = 13'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({resp_valid, resp_error, resp_rdata, mem_re, mem_we, mem_en, mem_addr, mem_din} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%0b re=%0b rd=%h mre=%0b mwe=%0b men=%0b ma=%h md=%h required all 0",
               resp_valid, resp_error, resp_rdata, mem_re, mem_we, mem_en, mem_addr, mem_din);
    end
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b required 1", req_ready);
    end
  endtask

  task automatic test_word();
    int lat, nacc, fe, elat, enacc;
    logic err, bad, rok, stk, eerr;
    logic [31:0] rd, erd;
    ref_txn(1'b1, 2'd2, 13'h0010, 32'hDEADBEEF, elat, eerr, erd, enacc);
    run_txn(1'b1, 2'd2, 13'h0010, 32'hDEADBEEF, lat, err, rd, nacc, fe, bad, rok, stk);
    checks++;
    if (lat !== 2 || err !== 1'b0 || nacc !== 2 || fe !== 1) begin
      errors++;
      $display("FAIL word_store: got lat=%0d err=%0b nacc=%0d first=%0d required lat=2 err=0 nacc=2 first=1", lat, err, nacc, fe);
    end
    checks++;
    if (mem[8] !== 16'hBEEF || mem[9] !== 16'hDEAD) begin
      errors++;
      $display("FAIL word_store_mem: got mem8=%h mem9=%h required BEEF DEAD", mem[8], mem[9]);
    end
    ref_txn(1'b0, 2'd2, 13'h0010, 32'h0, elat, eerr, erd, enacc);
    run_txn(1'b0, 2'd2, 13'h0010, 32'h0, lat, err, rd, nacc, fe, bad, rok, stk);
    checks++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'hDEADBEEF || nacc !== 2 || fe !== 1) begin
      errors++;
      $display("FAIL word_load: got lat=%0d err=%0b rd=%h nacc=%0d first=%0d required lat=3 err=0 rd=DEADBEEF nacc=2 first=1",
               lat, err, rd, nacc, fe);
    end
    checks++;
    if ({bad, stk, rok} !== 3'b001) begin
      errors++;
      $display("FAIL word_protocol: got bad_en=%0b stuck=%0b ready=%0b required 0 0 1", bad, stk, rok);
    end
  endtask

  task automatic test_byte();
    int lat, nacc, fe, elat, enacc;
    logic err, bad, rok, stk, eerr;
    logic [31:0] rd, erd;
    logic [15:0] emem8;
`ifdef MEMCTRL_BYTE_RMW_EN
    emem8 = 16'hA5EF;
`else
    emem8 = 16'hBEEF;
`endif
    ref_txn(1'b1, 2'd0, 13'h0011, 32'hFFFF_FFA5, elat, eerr, erd, enacc);
    run_txn(1'b1, 2'd0, 13'h0011, 32'hFFFF_FFA5, lat, err, rd, nacc, fe, bad, rok, stk);
    checks++;
    if (lat !== elat || err !== eerr || rd !== 32'h0 || nacc !== enacc || bad !== 1'b0) begin
      errors++;
      $display("FAIL byte_store: got lat=%0d err=%0b rd=%h nacc=%0d bad=%0b required lat=%0d err=%0b rd=0 nacc=%0d bad=0",
               lat, err, rd, nacc, bad, elat, eerr, enacc);
    end
    checks++;
    if (mem[8] !== emem8) begin
      errors++;
      $display("FAIL byte_store_mem: got mem8=%h required %h", mem[8], emem8);
    end
    ref_txn(1'b0, 2'd0, 13'h0011, 32'h0, elat, eerr, erd, enacc);
    run_txn(1'b0, 2'd0, 13'h0011, 32'h0, lat, err, rd, nacc, fe, bad, rok, stk);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== {24'h0, emem8[15:8]}) begin
      errors++;
      $display("FAIL byte_load: got lat=%0d err=%0b rd=%h required lat=2 err=0 rd=%h", lat, err, rd, {24'h0, emem8[15:8]});
    end
  endtask

  task automatic test_wrap();
    int lat, nacc, fe, elat, enacc;
    logic err, bad, rok, stk, eerr;
    logic [31:0] rd, erd;
    ref_txn(1'b1, 2'd2, 13'h1FFE, 32'h12345678, elat, eerr, erd, enacc);
    run_txn(1'b1, 2'd2, 13'h1FFE, 32'h12345678, lat, err, rd, nacc, fe, bad, rok, stk);
    checks++;
    if (mem[12'hFFF] !== 16'h5678 || mem[0] !== 16'h1234 || err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_store: got memFFF=%h mem000=%h err=%0b required 5678 1234 0", mem[12'hFFF], mem[0], err);
    end
    ref_txn(1'b0, 2'd2, 13'h1FFE, 32'h0, elat, eerr, erd, enacc);
    run_txn(1'b0, 2'd2, 13'h1FFE, 32'h0, lat, err, rd, nacc, fe, bad, rok, stk);
    checks++;
    if (rd !== 32'h12345678 || err !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL wrap_load: got rd=%h err=%0b lat=%0d required 12345678 0 3", rd, err, lat);
    end
  endtask

  task automatic test_misalign();
    int lat, nacc, fe, elat, enacc;
    logic err, bad, rok, stk, eerr;
    logic [31:0] rd, erd;
    ref_txn(1'b0, 2'd1, 13'h0003, 32'h0, elat, eerr, erd, enacc);
    run_txn(1'b0, 2'd1, 13'h0003, 32'h0, lat, err, rd, nacc, fe, bad, rok, stk);
    checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || nacc !== 0 || bad !== 1'b0) begin
      errors++;
      $display("FAIL misalign_half: got lat=%0d err=%0b rd=%h nacc=%0d bad=%0b required lat=1 err=1 rd=0 nacc=0 bad=0",
               lat, err, rd, nacc, bad);
    end
    run_txn(1'b1, 2'd3, 13'h0040, 32'h5555AAAA, lat, err, rd, nacc, fe, bad, rok, stk);
    checks++;
    if (lat !== 1 || err !== 1'b1 || nacc !== 0) begin
      errors++;
      $display("FAIL size_11: got lat=%0d err=%0b nacc=%0d required lat=1 err=1 nacc=0", lat, err, nacc);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] old11;
    logic seen;
    old11 = mem[12'h011];
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 13'h0020; req_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    // Reset is sampled on the edge that would move WR0 into WR1: low half lands, high half never issues.
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({resp_valid, mem_re, mem_we, mem_en, mem_addr, mem_din} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got rv=%0b re=%0b we=%0b en=%0b a=%h d=%h required all 0",
               resp_valid, mem_re, mem_we, mem_en, mem_addr, mem_din);
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_noresp: got resp_valid seen=%0b required 0", seen);
    end
    checks++;
    if (mem[12'h010] !== 16'hF00D || mem[12'h011] !== old11) begin
      errors++;
      $display("FAIL reset_mid_mem: got mem10=%h mem11=%h required F00D %h", mem[12'h010], mem[12'h011], old11);
    end
    ref_mem[12'h010] = 16'hF00D;
  endtask

  task automatic test_back_to_back();
    int elat, enacc;
    logic eerr;
    logic [31:0] erd;
    logic [2:0] vseq;
    ref_txn(1'b1, 2'd1, 13'h0004, 32'h0000_1234, elat, eerr, erd, enacc);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_addr = 13'h0004; req_wdata = 32'h0000_1234;
    @(posedge clock);
    #1;
    req_write = 1'b0; req_size = 2'd1; req_addr = 13'h0004; req_wdata = $urandom;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: got ready=%0b rv=%0b required 0 0", req_ready, resp_valid);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_store_resp: got rv=%0b err=%0b ready=%0b required 1 0 1", resp_valid, resp_error, req_ready);
    end
    ref_txn(1'b0, 2'd1, 13'h0004, 32'h0, elat, eerr, erd, enacc);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      vseq[c] = resp_valid;
    end
    checks++;
    if (vseq !== 3'b100 || resp_rdata !== 32'h0000_1234 || resp_error !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load: got valid_seq=%b rd=%h err=%0b required 100 00001234 0", vseq, resp_rdata, resp_error);
    end
  endtask

  task automatic test_random();
    int lat, nacc, fe, elat, enacc, efe, diffs;
    logic err, bad, rok, stk, eerr, w;
    logic [31:0] rd, erd, wd;
    logic [1:0] sz;
    logic [12:0] a;
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 13'h1FFC + 13'($urandom_range(0, 3)) : 13'($urandom);
      wd = $urandom;
      ref_txn(w, sz, a, wd, elat, eerr, erd, enacc);
      efe = enacc > 0 ? 1 : 0;
      run_txn(w, sz, a, wd, lat, err, rd, nacc, fe, bad, rok, stk);
      checks++;
      if (lat !== elat || err !== eerr || rd !== erd || nacc !== enacc || fe !== efe) begin
        errors++;
        $display("FAIL rand_txn[%0d] w=%0b sz=%0d a=%h: got lat=%0d err=%0b rd=%h nacc=%0d first=%0d required lat=%0d err=%0b rd=%h nacc=%0d first=%0d",
                 i, w, sz, a, lat, err, rd, nacc, fe, elat, eerr, erd, enacc, efe);
      end
      checks++;
      if ({bad, stk, rok} !== 3'b001) begin
        errors++;
        $display("FAIL rand_protocol[%0d]: got bad_en=%0b stuck=%0b ready=%0b required 0 0 1", i, bad, stk, rok);
      end
    end
    diffs = 0;
    for (int j = 0; j < 4096; j++) if (mem[j] !== ref_mem[j]) diffs++;
    checks++;
    if (diffs !== 0) begin
      errors++;
      $display("FAIL rand_mem_image: got %0d differing halfwords required 0", diffs);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_word();
    test_byte();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
